spi_rsp: RTL and testbench
==========================

# spi_rsp

SPI mode-0 responder (slave) that answers transactions issued by the team's `spi_drv` master. It oversamples SCLK, MOSI and SS_N in the local clock domain, shifts MOSI in on SCLK rising edges and drives MISO on falling edges. It presents a word-level interface to local logic: a holding register for outgoing data and a pulse-qualified result for incoming data.

## Interface
- SPI_MAXLEN, 32: maximum bits per transaction; width of the data registers.
- SYNC_STAGES, 2: flip-flop stages in each input synchronizer (≥2).
- clk  in  1  local clock.
- areset  in  1  reset, asynchronous, active-high.
- tx_wr  in  1  one-cycle strobe that writes tx_data/tx_len into the holding register.
- tx_data  in  SPI_MAXLEN  response word; the first bit sent is tx_data[tx_len-1].
- tx_len  in  $clog2(SPI_MAXLEN)+1  number of valid response bits (0..SPI_MAXLEN).
- busy  out  1  high while a transaction is active.
- tx_stale  out  1  sticky; set when a transaction starts with no tx_wr since the previous start. Cleared by tx_wr.
- rx_valid  out  1  one-cycle pulse at transaction end.
- rx_data  out  SPI_MAXLEN  received bits; the last bit is in [0].
- rx_len  out  $clog2(SPI_MAXLEN)+1  number of bits received, saturating at SPI_MAXLEN.
- rx_ovf  out  1  valid with rx_valid; more than SPI_MAXLEN SCLK rising edges were seen.
- SCLK, MOSI, SS_N  in  1  SPI pins from the master (asynchronous).
- MISO  out  1  data to the master.
- MISO_OE  out  1  tri-state enable for MISO; high only while busy.

## Operation
- The three SPI inputs pass through SYNC_STAGES flops. Edges are detected on the synchronized copies against one extra registered copy.
- FSM states:
  - ARM: wait for synchronized SS_N = 1, then go to IDLE.
  - IDLE: on SS_N falling edge go to ACTIVE and do the start actions below.
  - ACTIVE: on SS_N rising edge go to ARM and pulse rx_valid.
- Start actions on entering ACTIVE:
  - Copy the holding register into the tx shift register and tx_len into a bit pointer.
  - Drive MISO = tx_data[tx_len-1], or 0 if tx_len = 0.
  - Clear the rx shift register and rx count.
  - Set tx_stale if no tx_wr occurred since the previous start.
- On an SCLK rising edge in ACTIVE:
  - rx_shift <= {rx_shift[SPI_MAXLEN-2:0], MOSI_sync}.
  - rx count increments, saturating at SPI_MAXLEN; the overflow bit is set on the edge after saturation.
  - Only the last SPI_MAXLEN bits are kept.
- On an SCLK falling edge in ACTIVE:
  - The pointer decrements and MISO shows the next bit.
  - Once the pointer passes 0, MISO = 0 for all remaining edges.
- At transaction end, rx_data, rx_len and rx_ovf update in the same cycle as the rx_valid pulse. They hold until the next rx_valid.
- tx_wr is accepted in any state. A write during ACTIVE affects only the next transaction.
- A tx_wr in the same cycle as the start loads the new data into that transaction and does not set tx_stale.
- SCLK edges in IDLE or ARM are ignored.
- MISO = 0 and MISO_OE = 0 outside ACTIVE.
- Zero-edge transaction (SS_N low then high with no SCLK): rx_valid with rx_len = 0, rx_data = 0.

## Timing
- Reset values:
  - State ARM.
  - SS_N synchronizer 1; SCLK and MOSI synchronizers 0.
  - busy 0, MISO 0, MISO_OE 0, rx_valid 0.
  - rx_data 0, rx_len 0, rx_ovf 0, tx_stale 0.
  - Holding register 0, tx_len 0.
- Reset is asserted asynchronously and released synchronously.
- Reset mid-transaction aborts it with no rx_valid. The block re-arms only after SS_N is seen high, so a transaction already in progress is never joined partway.
- Pin-edge to action latency is SYNC_STAGES+1 clk cycles, applying to all of the following:
  - SS_N fall to busy and MISO_OE high and the first MISO bit valid.
  - SCLK rise to sample.
  - SCLK fall to MISO update.
  - SS_N rise to rx_valid.
- Required clk rate: the SCLK half-period and the SS_N-to-first-SCLK-rise time must each be ≥ SYNC_STAGES+3 clk periods. This is satisfied with spi_drv CLK_DIVIDE ≥ 2·(SYNC_STAGES+3) at an equal clock.
- MOSI is sampled from the synchronizer in the same cycle the SCLK rise is detected.

## Test plan
- Reset, tx_wr(tx_data=0xA5, tx_len=8); master sends 8 bits of 0x3C.
  - MISO bits in order 1,0,1,0,0,1,0,1.
  - rx_valid once with rx_data=0x0000003C, rx_len=8, rx_ovf=0, tx_stale=0.
- Two back-to-back 8-bit transactions with no second tx_wr.
  - The second sends 0xA5 again and tx_stale=1.
  - A following tx_wr clears tx_stale.
- tx_len=4 (0xF), master clocks 6 bits.
  - MISO = 1,1,1,1,0,0; rx_len=6.
- Master clocks 34 bits, all 1, with SPI_MAXLEN=32.
  - rx_len=32, rx_ovf=1, rx_data=0xFFFFFFFF.
- Assert areset after 3 SCLK edges, release while SS_N is still low.
  - No rx_valid, MISO_OE=0 for the rest of that transaction.
  - The next full transaction is received normally.
- SS_N pulse low for 10 cycles with no SCLK.
  - rx_valid with rx_len=0, rx_data=0.

Source files
------------

// File: rtl/spi_rsp.sv
// SPI mode-0 responder: synchronizes SCLK/MOSI/SS_N, samples MOSI on SCLK rise, shifts MISO on SCLK fall.
// Pin edge to action is SYNC_STAGES+1 clk; no backpressure, rx results are a one-cycle rx_valid pulse.
module spi_rsp #(
    parameter int SPI_MAXLEN  = 32,
    parameter int SYNC_STAGES = 2,
    localparam int LW = $clog2(SPI_MAXLEN) + 1,
    localparam int PW = $clog2(SPI_MAXLEN)
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  tx_wr,
    input  logic [SPI_MAXLEN-1:0] tx_data,
    input  logic [LW-1:0]         tx_len,
    output logic                  busy,
    output logic                  tx_stale,
    output logic                  rx_valid,
    output logic [SPI_MAXLEN-1:0] rx_data,
    output logic [LW-1:0]         rx_len,
    output logic                  rx_ovf,
    input  logic                  SCLK,
    input  logic                  MOSI,
    input  logic                  SS_N,
    output logic                  MISO,
    output logic                  MISO_OE
);
    localparam logic [LW-1:0] MAXL = LW'(SPI_MAXLEN);
    localparam logic [LW-1:0] ONE  = LW'(1);

    typedef enum logic [1:0] {ARM, IDLE, ACTIVE} state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  ss_sync_q, ss_sync_d, sclk_sync_q, sclk_sync_d, mosi_sync_q, mosi_sync_d;
    logic                    ss_prev_q, ss_prev_d, sclk_prev_q, sclk_prev_d;
    logic [SYNC_STAGES:0]    fill_q, fill_d;
    logic [SPI_MAXLEN-1:0]   hold_data_q, hold_data_d, tx_shift_q, tx_shift_d;
    logic [LW-1:0]           hold_len_q, hold_len_d, ptr_q, ptr_d;
    logic                    wr_seen_q, wr_seen_d, tx_stale_q, tx_stale_d;
    logic [SPI_MAXLEN-1:0]   rx_shift_q, rx_shift_d, rx_data_q, rx_data_d;
    logic [LW-1:0]           rx_cnt_q, rx_cnt_d, rx_len_q, rx_len_d;
    logic                    ovf_q, ovf_d, rx_valid_q, rx_valid_d, rx_ovf_q, rx_ovf_d;

    logic          ss_s, sclk_s, mosi_s, sync_ok;
    logic          ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic [LW-1:0] wr_len;
    logic [PW-1:0] miso_idx;

    assign ss_s      = ss_sync_q[SYNC_STAGES-1];
    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    // The edge detector only means something once reset values have flushed out of the chain.
    assign sync_ok   = fill_q[SYNC_STAGES];
    assign ss_fall   = ss_prev_q & ~ss_s;
    assign ss_rise   = ~ss_prev_q & ss_s;
    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign wr_len    = (tx_len > MAXL) ? MAXL : tx_len;
    assign miso_idx  = PW'(ptr_q - ONE);

    always_comb begin
        state_d     = state_q;
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], SS_N};
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        ss_prev_d   = ss_s;
        sclk_prev_d = sclk_s;
        fill_d      = {fill_q[SYNC_STAGES-1:0], 1'b1};
        hold_data_d = hold_data_q;
        hold_len_d  = hold_len_q;
        wr_seen_d   = wr_seen_q;
        tx_stale_d  = tx_stale_q;
        tx_shift_d  = tx_shift_q;
        ptr_d       = ptr_q;
        rx_shift_d  = rx_shift_q;
        rx_cnt_d    = rx_cnt_q;
        ovf_d       = ovf_q;
        rx_valid_d  = 1'b0;
        rx_data_d   = rx_data_q;
        rx_len_d    = rx_len_q;
        rx_ovf_d    = rx_ovf_q;

        if (tx_wr) begin
            hold_data_d = tx_data;
            hold_len_d  = wr_len;
            wr_seen_d   = 1'b1;
            tx_stale_d  = 1'b0;
        end

        case (state_q)
            ARM: begin
                if (sync_ok && ss_s) state_d = IDLE;
            end
            IDLE: begin
                if (ss_fall) begin
                    state_d    = ACTIVE;
                    // A write in the start cycle bypasses the holding register.
                    tx_shift_d = tx_wr ? tx_data : hold_data_q;
                    ptr_d      = tx_wr ? wr_len : hold_len_q;
                    rx_shift_d = '0;
                    rx_cnt_d   = '0;
                    ovf_d      = 1'b0;
                    wr_seen_d  = 1'b0;
                    tx_stale_d = ~(tx_wr | wr_seen_q);
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d    = ARM;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
                    rx_len_d   = rx_cnt_q;
                    rx_ovf_d   = ovf_q;
                end else begin
                    if (sclk_rise) begin
                        rx_shift_d = {rx_shift_q[SPI_MAXLEN-2:0], mosi_s};
                        if (rx_cnt_q == MAXL) ovf_d = 1'b1;
                        else                  rx_cnt_d = rx_cnt_q + ONE;
                    end
                    if (sclk_fall && ptr_q != '0) ptr_d = ptr_q - ONE;
                end
            end
            default: state_d = ARM;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= ARM;
            ss_sync_q   <= '1;
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            fill_q      <= '0;
            hold_data_q <= '0;
            hold_len_q  <= '0;
            wr_seen_q   <= 1'b0;
            tx_stale_q  <= 1'b0;
            tx_shift_q  <= '0;
            ptr_q       <= '0;
            rx_shift_q  <= '0;
            rx_cnt_q    <= '0;
            ovf_q       <= 1'b0;
            rx_valid_q  <= 1'b0;
            rx_data_q   <= '0;
            rx_len_q    <= '0;
            rx_ovf_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_prev_q   <= ss_prev_d;
            sclk_prev_q <= sclk_prev_d;
            fill_q      <= fill_d;
            hold_data_q <= hold_data_d;
            hold_len_q  <= hold_len_d;
            wr_seen_q   <= wr_seen_d;
            tx_stale_q  <= tx_stale_d;
            tx_shift_q  <= tx_shift_d;
            ptr_q       <= ptr_d;
            rx_shift_q  <= rx_shift_d;
            rx_cnt_q    <= rx_cnt_d;
            ovf_q       <= ovf_d;
            rx_valid_q  <= rx_valid_d;
            rx_data_q   <= rx_data_d;
            rx_len_q    <= rx_len_d;
            rx_ovf_q    <= rx_ovf_d;
        end
    end

    assign busy     = (state_q == ACTIVE);
    assign MISO_OE  = busy;
    assign MISO     = busy && (ptr_q != '0) && tx_shift_q[miso_idx];
    assign tx_stale = tx_stale_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_len   = rx_len_q;
    assign rx_ovf   = rx_ovf_q;
endmodule

// File: tb/tb_spi_rsp.sv
// Bench for spi_rsp: a mode-0 master task drives the pins; a word-level model predicts MISO bits and rx results.
// A monitor checks rx_valid timing/content and idle-pin rules on every clk cycle.
module tb_spi_rsp;
    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        tx_wr = 1'b0;
    logic [31:0] tx_data = '0;
    logic [5:0]  tx_len = '0;
    logic        busy, tx_stale, rx_valid, rx_ovf, MISO, MISO_OE;
    logic [31:0] rx_data;
    logic [5:0]  rx_len;
    logic        SCLK = 1'b0, MOSI = 1'b0, SS_N = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        int          len;
        bit          ovf;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [31:0] m_dat = '0;
    int          m_len = 0;
    bit          m_stale = 1'b0;
    bit          m_wr_since = 1'b0;
    bit          no_busy = 1'b0;
    logic [31:0] last_dat = '0;
    logic [5:0]  last_len = '0;
    logic        last_ovf = 1'b0;
    logic [63:0] got;

    spi_rsp dut (
        .clk(clk), .areset(areset), .tx_wr(tx_wr), .tx_data(tx_data), .tx_len(tx_len),
        .busy(busy), .tx_stale(tx_stale), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_len(rx_len), .rx_ovf(rx_ovf), .SCLK(SCLK), .MOSI(MOSI), .SS_N(SS_N),
        .MISO(MISO), .MISO_OE(MISO_OE)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (areset) begin
            last_dat = '0;
            last_len = '0;
            last_ovf = 1'b0;
        end else begin
            chk("miso_oe_eq_busy", MISO_OE, busy);
            if (!busy) chk("miso_zero_when_idle", MISO, 1'b0);
            if (no_busy) chk("no_rejoin_after_reset", busy, 1'b0);
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rx_valid", rx_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rx_valid_cycle", cyc, mon_e.cyc);
                    chk("rx_data", rx_data, mon_e.data);
                    chk("rx_len", rx_len, mon_e.len);
                    chk("rx_ovf", rx_ovf, mon_e.ovf);
                end
                last_dat = rx_data;
                last_len = rx_len;
                last_ovf = rx_ovf;
            end else begin
                if (exp_q.size() != 0 && cyc >= exp_q[0].cyc) begin
                    chk("rx_valid_missing", rx_valid, 1'b1);
                    void'(exp_q.pop_front());
                end
                chk("rx_hold", {rx_ovf, rx_len, rx_data}, {last_ovf, last_len, last_dat});
            end
        end
    end

    task automatic do_wr(input logic [31:0] d, input int l);
        @(negedge clk);
        tx_data = d;
        tx_len  = 6'(l);
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr = 1'b0;
        m_dat = d;
        m_len = l;
        m_wr_since = 1'b1;
        m_stale = 1'b0;
        chk("tx_stale_cleared_by_wr", tx_stale, 1'b0);
    endtask

    // One mode-0 transaction; MOSI bits go out from mo[nbits-1] down to mo[0].
    task automatic xfer(input int nbits, input logic [63:0] mo, input int hp, input bit wr_start,
                        input logic [31:0] wdat, input int wlen, output logic [63:0] gv);
        exp_t        e;
        logic [31:0] mask;
        logic        exp_bit;
        gv = '0;
        @(negedge clk);
        SS_N = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("busy_not_early", busy, 1'b0);
        if (wr_start) begin
            tx_data = wdat;
            tx_len  = 6'(wlen);
            tx_wr   = 1'b1;
        end
        @(negedge clk);
        tx_wr = 1'b0;
        chk("busy_at_latency", busy, 1'b1);
        if (wr_start) begin
            m_dat = wdat;
            m_len = wlen;
            m_stale = 1'b0;
        end else if (!m_wr_since) begin
            m_stale = 1'b1;
        end
        m_wr_since = 1'b0;
        chk("tx_stale_at_start", tx_stale, m_stale);
        for (int i = 0; i < nbits; i++) begin
            MOSI = mo[nbits-1-i];
            repeat (hp) @(negedge clk);
            exp_bit = (i < m_len) ? m_dat[m_len-1-i] : 1'b0;
            chk("miso_oe_active", MISO_OE, 1'b1);
            chk("miso_bit", MISO, exp_bit);
            gv = {gv[62:0], MISO};
            SCLK = 1'b1;
            repeat (hp) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (hp) @(negedge clk);
        SS_N = 1'b1;
        MOSI = 1'b0;
        mask   = (nbits >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nbits) - 32'd1);
        e.cyc  = cyc + 3;
        e.data = mo[31:0] & mask;
        e.len  = (nbits > 32) ? 32 : nbits;
        e.ovf  = (nbits > 32);
        exp_q.push_back(e);
        repeat (hp + 6) @(negedge clk);
    endtask

    task automatic sclk_pulse(input int hp);
        SCLK = 1'b1;
        repeat (hp) @(negedge clk);
        SCLK = 1'b0;
        repeat (hp) @(negedge clk);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb, hp, mode, wl;
        logic [63:0] mo;
        logic [31:0] wd;

        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_miso", MISO, 1'b0);
        chk("reset_miso_oe", MISO_OE, 1'b0);
        chk("reset_rx_valid", rx_valid, 1'b0);
        chk("reset_rx_data", rx_data, 32'h0);
        chk("reset_rx_len", rx_len, 6'h0);
        chk("reset_rx_ovf", rx_ovf, 1'b0);
        chk("reset_tx_stale", tx_stale, 1'b0);
        areset = 1'b0;
        repeat (6) @(negedge clk);

        // SCLK activity with SS_N high must not reach the rx shifter.
        MOSI = 1'b1;
        repeat (2) sclk_pulse(6);
        MOSI = 1'b0;

        do_wr(32'hA5, 8);
        xfer(8, 64'h3C, 8, 1'b0, '0, 0, got);
        chk("t1_miso_seq", got[7:0], 8'hA5);
        chk("t1_rx_data", last_dat, 32'h0000_003C);
        chk("t1_rx_len", last_len, 6'd8);
        chk("t1_rx_ovf", last_ovf, 1'b0);
        chk("t1_tx_stale", tx_stale, 1'b0);

        xfer(8, 64'h5A, 8, 1'b0, '0, 0, got);
        chk("t2_miso_repeat", got[7:0], 8'hA5);
        chk("t2_tx_stale_set", tx_stale, 1'b1);
        chk("t2_rx_data", last_dat, 32'h0000_005A);
        do_wr(32'h1, 1);
        chk("t2_tx_stale_clear", tx_stale, 1'b0);

        do_wr(32'hF, 4);
        xfer(6, 64'h2B, 6, 1'b0, '0, 0, got);
        chk("t3_miso_seq", got[5:0], 6'b111100);
        chk("t3_rx_len", last_len, 6'd6);
        chk("t3_rx_data", last_dat, 32'h0000_002B);

        do_wr(32'hDEAD_BEEF, 32);
        xfer(34, 64'h3_FFFF_FFFF, 5, 1'b0, '0, 0, got);
        chk("t4_rx_len", last_len, 6'd32);
        chk("t4_rx_ovf", last_ovf, 1'b1);
        chk("t4_rx_data", last_dat, 32'hFFFF_FFFF);

        xfer(8, 64'hC3, 6, 1'b1, 32'h81, 8, got);
        chk("t5_start_wr_data", got[7:0], 8'h81);
        chk("t5_start_wr_no_stale", tx_stale, 1'b0);

        // Reset in the middle of a transaction: the rest of it must be ignored.
        do_wr(32'hA5, 8);
        @(negedge clk);
        SS_N = 1'b0;
        repeat (8) @(negedge clk);
        MOSI = 1'b1;
        sclk_pulse(6);
        SCLK = 1'b1;
        repeat (6) @(negedge clk);
        areset = 1'b1;
        no_busy = 1'b1;
        #1;
        chk("t6_reset_busy", busy, 1'b0);
        chk("t6_reset_miso_oe", MISO_OE, 1'b0);
        chk("t6_reset_rx_len", rx_len, 6'd0);
        repeat (2) @(negedge clk);
        areset = 1'b0;
        m_dat = '0;
        m_len = 0;
        m_stale = 1'b0;
        m_wr_since = 1'b0;
        repeat (6) @(negedge clk);
        SCLK = 1'b0;
        repeat (6) @(negedge clk);
        repeat (3) sclk_pulse(6);
        SS_N = 1'b1;
        MOSI = 1'b0;
        repeat (10) @(negedge clk);
        no_busy = 1'b0;
        do_wr(32'h3C, 8);
        xfer(8, 64'h96, 7, 1'b0, '0, 0, got);
        chk("t6_after_reset_miso", got[7:0], 8'h3C);
        chk("t6_after_reset_rx", last_dat, 32'h0000_0096);

        xfer(0, 64'h0, 5, 1'b0, '0, 0, got);
        chk("t7_zero_rx_len", last_len, 6'd0);
        chk("t7_zero_rx_data", last_dat, 32'h0);

        for (int k = 0; k < 20; k++) begin
            nb   = $urandom_range(0, 36);
            hp   = $urandom_range(5, 9);
            mode = $urandom_range(0, 3);
            wl   = $urandom_range(0, 32);
            wd   = $urandom;
            mo   = {$urandom, $urandom};
            if (mode == 1 || mode == 2) do_wr(wd, wl);
            xfer(nb, mo, hp, mode == 3, wd, wl, got);
        end

        repeat (20) @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
